oam_dma_ctrl: RTL and testbench



---
 rtl/oam_dma_ctrl.sv | 161 ++++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: copies one 256-byte page of CPU RAM into PPU OAM.
//
// A CPU write to DMA_REG_ADDR while idle latches the source page and halts the
// CPU. After an alignment cycle the block alternates READ (RAM read strobe) and
// WRITE (OAM write strobe) 256 times, then releases the CPU.
//
// Optional build macro: OAM_DMA_ODD_CYCLE_EN
//   When defined, a free-running parity flop tracks CPU cycle parity since
//   reset. A trigger sampled on an odd cycle adds one extra ALIGN cycle.
//
// Ports
//   clk          system clock, one edge per CPU cycle
//   reset        asynchronous active-low reset
//   cpu_wr       CPU write strobe
//   cpu_addr     CPU bus address
//   cpu_data_in  CPU write data (source page number)
//   cpu_stall    CPU halt, high whenever a transfer is in progress
//   mem_addr     CPU-RAM read address, held outside READ
//   mem_rd       CPU-RAM read strobe
//   mem_data_in  CPU-RAM read data, valid the cycle after mem_rd
//   oam_dma      OAM write enable
//   oam_addr     OAM byte index, held outside WRITE
//   oam_data_in  OAM write data, held outside WRITE
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_in
);

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRead,
    StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] mem_addr_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_data_q;
  logic        trigger;
  logic        align_last;

  // Trigger is only honoured in IDLE, so a write during a transfer is ignored.
  assign trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR) && (state_q == StIdle);

`ifdef OAM_DMA_ODD_CYCLE_EN
  logic parity_q;
  logic extra_q, extra_d;

  // extra_q records that the trigger landed on an odd cycle; ALIGN spends one
  // cycle clearing it before moving on.
  assign align_last = ~extra_q;

  always_comb begin
    extra_d = extra_q;
    if (trigger) begin
      extra_d = parity_q;
    end else if (state_q == StAlign) begin
      extra_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
      extra_q  <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      extra_q  <= extra_d;
    end
  end
`else
  assign align_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trigger) state_d = StAlign;
      StAlign: if (align_last) state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: state_d = (idx_q == 8'hFF) ? StIdle : StRead;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; address/data buses hold their last driven value between strobes.
  always_comb begin
    cpu_stall   = (state_q != StIdle);
    mem_rd      = 1'b0;
    oam_dma     = 1'b0;
    mem_addr    = mem_addr_q;
    oam_addr    = oam_addr_q;
    oam_data_in = oam_data_q;
    unique case (state_q)
      StRead: begin
        mem_rd   = 1'b1;
        mem_addr = {page_q, idx_q};
      end
      StWrite: begin
        oam_dma     = 1'b1;
        oam_addr    = idx_q;
        oam_data_in = mem_data_in;
      end
      default: ;
    endcase
  end

  // Page / index datapath
  always_comb begin
    page_d = page_q;
    idx_d  = idx_q;
    if (trigger) begin
      page_d = cpu_data_in;
      idx_d  = 8'h00;
    end else if (state_q == StWrite) begin
      idx_d = idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      mem_addr_q <= 16'h0000;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
    end else begin
      page_q     <= page_d;
      idx_q      <= idx_d;
      mem_addr_q <= mem_addr;
      oam_addr_q <= oam_addr;
      oam_data_q <= oam_data_in;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomised self-checking bench for oam_dma_ctrl. A behavioural RAM model
// answers reads; each transfer is checked against the expected 256-write
// sequence, read addresses, stall length and alignment latency.
module tb_oam_dma_ctrl;

  localparam logic [15:0] DmaAddr = 16'h4014;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_in;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;

  logic [7:0]  ram [0:65535];
  int unsigned cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  oam_dma_ctrl #(.DMA_REG_ADDR(DmaAddr)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_stall   (cpu_stall),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data_in (mem_data_in),
    .oam_dma     (oam_dma),
    .oam_addr    (oam_addr),
    .oam_data_in (oam_data_in)
  );

  always #5 clk = ~clk;

  // RAM answers one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data_in <= ram[mem_addr];
  end

  // Cycles since reset release; bit 0 is the CPU cycle parity.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues a trigger (caller must be at a negedge) and follows the transfer.
  // retrig_at: cycle index at which a second trigger write of 8'h07 is issued.
  // rst_at: number of OAM writes after which reset is asserted (aborts).
  task automatic run_xfer(input logic [7:0] page, input int retrig_at, input int rst_at);
    int stall_n, wr_n, rd_n, first_rd;
    bit odd, done, aborted;
    logic [7:0] k;
    odd = 1'b0;
`ifdef OAM_DMA_ODD_CYCLE_EN
    odd = cyc[0];
`endif
    cpu_wr = 1'b1; cpu_addr = DmaAddr; cpu_data_in = page;
    stall_n = 0; wr_n = 0; rd_n = 0; first_rd = 0; done = 0; aborted = 0;
    for (int n = 0; n < 700 && !done; n++) begin
      @(negedge clk);
      cpu_wr = 1'b0; cpu_addr = 16'($urandom); cpu_data_in = 8'($urandom);
      if (n == retrig_at) begin
        cpu_wr = 1'b1; cpu_addr = DmaAddr; cpu_data_in = 8'h07;
      end
      if (cpu_stall) stall_n++;
      if (mem_rd) begin
        if (rd_n == 0) first_rd = stall_n;
        k = rd_n[7:0];
        check("rd_addr", {16'h0, mem_addr}, {16'h0, page, k});
        rd_n++;
      end
      if (oam_dma) begin
        k = wr_n[7:0];
        check("oam_addr", {24'h0, oam_addr}, {24'h0, k});
        check("oam_data", {24'h0, oam_data_in}, {24'h0, ram[{page, k}]});
        wr_n++;
        if (wr_n == rst_at) begin
          reset = 1'b0;
          #1;
          check("abort_stall", {31'h0, cpu_stall}, 32'h0);
          check("abort_oam_dma", {31'h0, oam_dma}, 32'h0);
          aborted = 1'b1;
          done = 1'b1;
        end
      end else if (wr_n > 0 && cpu_stall) begin
        k = 8'(wr_n - 1);
        check("oam_addr_hold", {24'h0, oam_addr}, {24'h0, k});
      end
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) check("timeout", 32'h0, 32'h1);
    if (!aborted && done) begin
      check("stall_len", stall_n, 513 + int'(odd));
      check("write_count", wr_n, 256);
      check("read_count", rd_n, 256);
      check("first_rd_lat", first_rd, 2 + int'(odd));
      check("end_oam_addr", {24'h0, oam_addr}, 32'hFF);
      check("end_oam_data", {24'h0, oam_data_in}, {24'h0, ram[{page, 8'hFF}]});
      check("end_mem_addr", {16'h0, mem_addr}, {16'h0, page, 8'hFF});
      check("end_strobes", {30'h0, mem_rd, oam_dma}, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data_in = 8'h0;
    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'h5A;

    idle(3);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_strobes", {30'h0, mem_rd, oam_dma}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_oam_addr", {24'h0, oam_addr}, 32'h0);
    check("rst_oam_data", {24'h0, oam_data_in}, 32'h0);

    // First trigger right after release, on the first rising edge.
    reset = 1'b1;
    run_xfer(8'h02, -1, -1);

    // Retrigger mid-transfer is ignored.
    idle(int'($urandom_range(1, 3)));
    run_xfer(8'h02, 100, -1);

    // Writes to neighbouring addresses do nothing.
    idle(1);
    cpu_wr = 1'b1; cpu_addr = 16'h4013; cpu_data_in = 8'($urandom);
    @(negedge clk);
    cpu_addr = 16'h4015;
    @(negedge clk);
    cpu_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("nontrig_stall", {31'h0, cpu_stall}, 32'h0);
      check("nontrig_rd", {31'h0, mem_rd}, 32'h0);
      @(negedge clk);
    end

    // Top page: no carry into a neighbouring page.
    run_xfer(8'hFF, -1, -1);

    // Back-to-back: second trigger on the cycle IDLE is re-entered.
    idle(1);
    run_xfer(8'($urandom), -1, -1);
    run_xfer(8'($urandom), -1, -1);

    // Reset after 40 writes aborts; nothing resumes after release.
    idle(2);
    run_xfer(8'($urandom), -1, 40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_rst_oam_dma", {31'h0, oam_dma}, 32'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_idle", {30'h0, cpu_stall, oam_dma}, 32'h0);
    end
    run_xfer(8'($urandom), -1, -1);

    // Random pages with both start parities.
    for (int t = 0; t < 4; t++) begin
      idle(t % 2 + 1);
      run_xfer(8'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
